data_mem_lsu: RTL and testbench

Load/store initiator driving the single-port data memory from the processor side. Accepts one load or store request at a time from the execute stage over a valid/ready handshake and generates the memory's address, write-data, write-enable and read-enable signals from registers. Returns load data, or a store completion, over a response handshake. Sits between the execute/memory pipeline stage and the data memory.

---
 rtl/data_mem_lsu_pkg.sv | 26 ++
 rtl/data_mem_lsu_if.sv | 59 +++++
 rtl/data_mem_lsu.sv | 117 +++++++++++
 tb/tb_data_mem_lsu.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/data_mem_lsu_pkg.sv
// -----------------------------------------------------------------------------
// data_mem_lsu_pkg
// Shared definitions for the load/store unit and the data memory behind it:
//   - lsu_state_t  : LSU FSM state encoding (IDLE / ACCESS / RESP)
//   - DATA_W_DEF   : default data word width
//   - ADDR_W_DEF   : default address width (request side and memory side)
//   - DEPTH        : implemented memory rows; memory and LSU must agree on it
//   - addr_in_range: helper used by the optional bounds check
// -----------------------------------------------------------------------------
package data_mem_lsu_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int ADDR_W_DEF = 16;
    localparam int DEPTH      = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } lsu_state_t;

    function automatic logic addr_in_range(input logic [ADDR_W_DEF-1:0] addr);
        return (addr < ADDR_W_DEF'(DEPTH));
    endfunction

endpackage

// File: rtl/data_mem_lsu_if.sv
// -----------------------------------------------------------------------------
// data_mem_lsu_if
// Bundles the request handshake, the response handshake and the data-memory
// bus of the LSU.
//   Request : req_valid, req_ready, req_we, req_addr, req_wdata
//   Response: rsp_valid, rsp_ready, rsp_rdata, rsp_err
//   Memory  : mem_access_addr, mem_write_data, mem_write_en, mem_read,
//             mem_read_data (combinational return from the memory)
// Modports:
//   slave  : the LSU's view
//   master : the environment's view (execute stage + data memory)
//
// Handshake rule (both channels): a transfer happens at a rising edge where
// valid and ready are both 1. Once valid is raised, the payload stays stable
// until that edge; ready may change freely and never depends on valid.
// -----------------------------------------------------------------------------
interface data_mem_lsu_if
    import data_mem_lsu_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) ();

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_access_addr;
    logic [DATA_W-1:0] mem_write_data;
    logic              mem_write_en;
    logic              mem_read;
    logic [DATA_W-1:0] mem_read_data;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_access_addr, mem_write_data, mem_write_en, mem_read,
        input  mem_read_data
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_access_addr, mem_write_data, mem_write_en, mem_read,
        output mem_read_data
    );

endinterface

// File: rtl/data_mem_lsu.sv
// -----------------------------------------------------------------------------
// data_mem_lsu
// Load/store initiator for the single-port data memory. Takes one request at a
// time from the execute stage, drives the memory from registers for exactly
// one ACCESS cycle, then holds the response until it is consumed.
//
// Ports:
//   clk     : clock, all state changes on the rising edge
//   rst     : asynchronous, active-high reset
//   bus     : data_mem_lsu_if.slave (request, response and memory signals)
//   o_state : current FSM state, for observation
//
// Optional feature macro: DATA_MEM_LSU_BOUNDS_CHECK_EN
//   defined  : requests with addr >= DEPTH pass through ACCESS without any
//              memory strobe and complete with rsp_err=1, rsp_rdata=0
//   undefined: no check, the memory aliases on the low address bits and
//              rsp_err is constant 0
// -----------------------------------------------------------------------------
module data_mem_lsu
    import data_mem_lsu_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    data_mem_lsu_if.slave bus,
    output lsu_state_t    o_state
);

    lsu_state_t              r_state;
    logic                    r_we;
    logic                    r_in_range;
    logic                    r_req_ready;
    logic                    r_rsp_valid;
    logic [DATA_W_DEF-1:0]   r_rsp_rdata;
    logic [ADDR_W_DEF-1:0]   r_mem_addr;
    logic [DATA_W_DEF-1:0]   r_mem_wdata;
    logic                    r_mem_we;
    logic                    r_mem_rd;
    logic                    w_in_range;

`ifdef DATA_MEM_LSU_BOUNDS_CHECK_EN
    logic                    r_rsp_err;
    assign w_in_range  = addr_in_range(bus.req_addr);
    assign bus.rsp_err = r_rsp_err;
`else
    assign w_in_range  = 1'b1;
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_we        <= 1'b0;
            r_in_range  <= 1'b1;
            r_req_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= '0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_we    <= 1'b0;
            r_mem_rd    <= 1'b0;
`ifdef DATA_MEM_LSU_BOUNDS_CHECK_EN
            r_rsp_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.req_valid && r_req_ready) begin
                        // Strobes are set here so they are registered and
                        // high for exactly the ACCESS cycle that follows.
                        r_state     <= ST_ACCESS;
                        r_req_ready <= 1'b0;
                        r_we        <= bus.req_we;
                        r_in_range  <= w_in_range;
                        r_mem_addr  <= bus.req_addr;
                        r_mem_wdata <= bus.req_wdata;
                        r_mem_we    <= bus.req_we && w_in_range;
                        r_mem_rd    <= !bus.req_we && w_in_range;
                    end
                end
                ST_ACCESS: begin
                    r_state     <= ST_RESP;
                    r_mem_we    <= 1'b0;
                    r_mem_rd    <= 1'b0;
                    r_rsp_valid <= 1'b1;
                    // Memory read data is combinational, so it is valid at
                    // the edge that ends ACCESS.
                    r_rsp_rdata <= (r_we || !r_in_range) ? '0 : bus.mem_read_data;
`ifdef DATA_MEM_LSU_BOUNDS_CHECK_EN
                    r_rsp_err   <= !r_in_range;
`endif
                end
                ST_RESP: begin
                    // req_ready returns one cycle after the response
                    // handshake; no same-cycle turnaround.
                    if (bus.rsp_ready) begin
                        r_state     <= ST_IDLE;
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready       = r_req_ready;
    assign bus.rsp_valid       = r_rsp_valid;
    assign bus.rsp_rdata       = r_rsp_rdata;
    assign bus.mem_access_addr = r_mem_addr;
    assign bus.mem_write_data  = r_mem_wdata;
    assign bus.mem_write_en    = r_mem_we;
    assign bus.mem_read        = r_mem_rd;
    assign o_state             = r_state;

endmodule

// File: tb/tb_data_mem_lsu.sv
// -----------------------------------------------------------------------------
// tb_data_mem_lsu
// Self-checking bench for data_mem_lsu with an 8-word behavioural memory.
// Expected responses are pushed to a queue when a request is driven and are
// popped when the response handshake is observed. Honours the optional macro
// DATA_MEM_LSU_BOUNDS_CHECK_EN for the out-of-range step.
// -----------------------------------------------------------------------------
module tb_data_mem_lsu;
    import data_mem_lsu_pkg::*;

    localparam int W = 17;  // {err, rdata}

    logic       clk;
    logic       rst;
    lsu_state_t state;

    data_mem_lsu_if #(.DATA_W(16), .ADDR_W(16)) bus ();

    data_mem_lsu dut (
        .clk     (clk),
        .rst     (rst),
        .bus     (bus.slave),
        .o_state (state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural memory ----------------
    logic [15:0] mem [8] = '{default: 16'h0000};
    assign bus.mem_read_data = mem[bus.mem_access_addr[2:0]];
    always @(posedge clk) begin
        if (bus.mem_write_en) mem[bus.mem_access_addr[2:0]] <= bus.mem_write_data;
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0] exp_q[$];
    logic [15:0]  ref_mem [8] = '{default: 16'h0000};
    int           n_cmp = 0;
    int           n_err = 0;
    int           n_rsp = 0;
    int           n_we_cyc = 0;
    int           n_rd_cyc = 0;
    longint       acc_time = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Response monitor: sampled on the falling edge, mid-cycle.
    always @(negedge clk) begin
        logic [W-1:0] e;
        if (!rst) begin
            check("we_rd_exclusive", {31'd0, bus.mem_write_en && bus.mem_read}, 32'd0);
            if (bus.mem_write_en) n_we_cyc++;
            if (bus.mem_read)     n_rd_cyc++;
            if (bus.rsp_valid && bus.rsp_ready) begin
                check("rsp_expected", {31'd0, exp_q.size() != 0}, 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("rsp_rdata", {16'd0, bus.rsp_rdata}, {16'd0, e[15:0]});
                    check("rsp_err", {31'd0, bus.rsp_err}, {31'd0, e[16]});
                end
                n_rsp++;
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 right after the acceptance edge.
    task automatic send(input logic we, input logic [15:0] addr, input logic [15:0] wd,
                        input logic push);
        int          n = 0;
        logic        bnd;
        logic [W-1:0] e;
        while (!bus.req_ready && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        check("req_ready_timeout", {31'd0, n < 20}, 32'd1);
`ifdef DATA_MEM_LSU_BOUNDS_CHECK_EN
        bnd = (addr >= 16'd8);
`else
        bnd = 1'b0;
`endif
        if (push) begin
            if (we) begin
                e = {bnd, 16'h0000};
                if (!bnd) ref_mem[addr[2:0]] = wd;
            end else begin
                e = {bnd, bnd ? 16'h0000 : ref_mem[addr[2:0]]};
            end
            exp_q.push_back(e);
        end
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wd;
        @(posedge clk);
        acc_time = $time;
        #1;
        bus.req_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((exp_q.size() != 0 || !bus.req_ready) && n < 30) begin
            @(posedge clk); #1;
            n++;
        end
        check("drain_timeout", {31'd0, n < 30}, 32'd1);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int     base;
        longint last;

        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_we    = 1'b0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset state
        #1 rst = 1'b1;
        #2;
        check("rst_state", 32'(state), 32'(ST_IDLE));
        check("rst_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rst_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rst_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        check("rst_rsp_err", {31'd0, bus.rsp_err}, 32'd0);
        check("rst_mem_addr", {16'd0, bus.mem_access_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, bus.mem_write_data}, 32'd0);
        check("rst_mem_we", {31'd0, bus.mem_write_en}, 32'd0);
        check("rst_mem_rd", {31'd0, bus.mem_read}, 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;

        // Store addr 3 <- A5A5
        base = n_we_cyc;
        send(1'b1, 16'd3, 16'hA5A5, 1'b1);
        check("st_state_access", 32'(state), 32'(ST_ACCESS));
        check("st_mem_we", {31'd0, bus.mem_write_en}, 32'd1);
        check("st_mem_rd", {31'd0, bus.mem_read}, 32'd0);
        check("st_mem_addr", {16'd0, bus.mem_access_addr}, 32'd3);
        check("st_mem_wdata", {16'd0, bus.mem_write_data}, 32'h0000A5A5);
        @(posedge clk); #1;
        check("st_state_resp", 32'(state), 32'(ST_RESP));
        check("st_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
        check("st_we_dropped", {31'd0, bus.mem_write_en}, 32'd0);
        check("st_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'd0);
        @(posedge clk); #1;
        check("st_back_idle", 32'(state), 32'(ST_IDLE));
        check("st_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("st_rsp_dropped", {31'd0, bus.rsp_valid}, 32'd0);
        check("st_mem_committed", {16'd0, mem[3]}, 32'h0000A5A5);
        drain();
        check("st_we_cycles", n_we_cyc - base, 32'd1);

        // Load addr 3
        base = n_rd_cyc;
        send(1'b0, 16'd3, 16'h0000, 1'b1);
        check("ld_mem_rd", {31'd0, bus.mem_read}, 32'd1);
        check("ld_mem_we", {31'd0, bus.mem_write_en}, 32'd0);
        check("ld_mem_addr", {16'd0, bus.mem_access_addr}, 32'd3);
        drain();
        check("ld_rd_cycles", n_rd_cyc - base, 32'd1);

        // Response stall with a stray request pulse
        bus.rsp_ready = 1'b0;
        send(1'b0, 16'd3, 16'h0000, 1'b1);
        @(posedge clk); #1;
        for (int k = 0; k < 5; k++) begin
            check("stall_rsp_valid", {31'd0, bus.rsp_valid}, 32'd1);
            check("stall_rsp_rdata", {16'd0, bus.rsp_rdata}, 32'h0000A5A5);
            check("stall_req_ready", {31'd0, bus.req_ready}, 32'd0);
            check("stall_state", 32'(state), 32'(ST_RESP));
            if (k == 1) begin
                bus.req_valid = 1'b1;
                bus.req_we    = 1'b1;
                bus.req_addr  = 16'd5;
                bus.req_wdata = 16'hDEAD;
            end
            if (k == 2) bus.req_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.rsp_ready = 1'b1;
        drain();
        send(1'b0, 16'd5, 16'h0000, 1'b1);
        drain();

        // Preload 0..7 back-to-back, then back-to-back loads
        last = 0;
        for (int i = 0; i < 8; i++) begin
            send(1'b1, 16'(i), 16'(i), 1'b1);
            if (i > 0) check("st_spacing", 32'(acc_time - last), 32'd30);
            last = acc_time;
        end
        drain();
        for (int i = 0; i < 8; i++) begin
            send(1'b0, 16'(i), 16'h0000, 1'b1);
            if (i > 0) check("ld_spacing", 32'(acc_time - last), 32'd30);
            last = acc_time;
        end
        drain();

        // Reset during the ACCESS cycle of a store
        base = n_rsp;
        send(1'b1, 16'd6, 16'h1234, 1'b0);
        check("rstmid_mem_we_pre", {31'd0, bus.mem_write_en}, 32'd1);
        rst = 1'b1;
        #1;
        check("rstmid_mem_we", {31'd0, bus.mem_write_en}, 32'd0);
        check("rstmid_rsp_valid", {31'd0, bus.rsp_valid}, 32'd0);
        check("rstmid_req_ready", {31'd0, bus.req_ready}, 32'd1);
        check("rstmid_state", 32'(state), 32'(ST_IDLE));
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            check("rstmid_no_rsp", {31'd0, bus.rsp_valid}, 32'd0);
        end
        check("rstmid_ready_after", {31'd0, bus.req_ready}, 32'd1);
        check("rstmid_rsp_count", n_rsp - base, 32'd0);
        ref_mem[6] = mem[6];

        // Out-of-range store, then load from addr 1
        base = n_we_cyc;
        send(1'b1, 16'd9, 16'h5A5A, 1'b1);
`ifdef DATA_MEM_LSU_BOUNDS_CHECK_EN
        check("oor_mem_we", {31'd0, bus.mem_write_en}, 32'd0);
        check("oor_mem_rd", {31'd0, bus.mem_read}, 32'd0);
        drain();
        check("oor_we_cycles", n_we_cyc - base, 32'd0);
`else
        check("alias_mem_we", {31'd0, bus.mem_write_en}, 32'd1);
        check("alias_mem_addr", {16'd0, bus.mem_access_addr}, 32'd9);
        drain();
        check("alias_we_cycles", n_we_cyc - base, 32'd1);
`endif
        send(1'b0, 16'd1, 16'h0000, 1'b1);
        drain();

        check("queue_empty", exp_q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Global watchdog
    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
